// File: rtl/i2s_rx_multi_if.sv
// Frame stream from the multi-channel I2S/TDM receiver to the capture side.
// The master drives completed frames and status pulses; the slave returns ready.
interface i2s_rx_multi_if #(
    parameter int DW = 64
) ();
    logic [DW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          overrun;
    logic          sync_err;
    logic          synced;

    modport master (
        output frame_data,
        output frame_valid,
        output overrun,
        output sync_err,
        output synced,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        input  overrun,
        input  sync_err,
        input  synced,
        output frame_ready
    );
endinterface

// File: rtl/i2s_rx_multi.sv
// Multi-slot I2S / left-justified receiver. Deserialises NUM_CH slots of
// SLOT_W bits per lrclk frame, keeps the top AUDIO_DW bits of each slot and
// presents the whole frame on a valid/ready stream with overrun and
// frame-position error pulses.
module i2s_rx_multi #(
    parameter int AUDIO_DW = 32,
    parameter int SLOT_W   = 32,
    parameter int NUM_CH   = 2
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               lrclk,
    input  logic               sdata,
    input  logic               mode_lj,
    i2s_rx_multi_if.master     frm
);
    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int PW         = $clog2(FRAME_BITS + 2);
    localparam int OW         = NUM_CH * AUDIO_DW;
    localparam logic [PW-1:0] P_FB   = PW'(FRAME_BITS);
    localparam logic [PW-1:0] P_SAT  = PW'(FRAME_BITS + 1);
    localparam logic [PW-1:0] P_LAST = PW'((NUM_CH - 1) * SLOT_W + AUDIO_DW - 1);

    // Position counter stops one past the frame end so a missing frame
    // start is caught as an error instead of wrapping.
    function automatic logic [PW-1:0] f_pos_inc(input logic [PW-1:0] p);
        return (p == P_SAT) ? P_SAT : p + 1'b1;
    endfunction

    logic                r_lrclk;
    logic                r_edge_d;
    logic                r_synced;
    logic [PW-1:0]       r_pos;
    logic [AUDIO_DW-2:0] r_sh;
    logic [OW-1:0]       r_buf;
    logic [OW-1:0]       r_data;
    logic                r_valid;
    logic                r_overrun;
    logic                r_sync_err;

    logic                w_edge;
    logic                w_align;
    logic                w_sync_bad;
    logic                w_complete;
    logic                w_free;
    logic [AUDIO_DW-1:0] w_word;
    logic [OW-1:0]       w_frame;

    // ---- frame alignment: lrclk fall, delayed one bit in I2S mode ----
    assign w_edge     = !lrclk && r_lrclk;
    assign w_align    = mode_lj ? w_edge : r_edge_d;
    // r_pos holds the position the current bit would have without an align;
    // a correct frame start therefore sees exactly FRAME_BITS here.
    assign w_sync_bad = w_align && r_synced && (r_pos != P_FB);
    assign w_complete = r_synced && (r_pos == P_LAST);
    assign w_free     = !r_valid || frm.frame_ready;
    assign w_word     = {r_sh, sdata};

    // Track lrclk history and the delayed edge used for I2S alignment.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_lrclk  <= 1'b1;
            r_edge_d <= 1'b0;
        end else begin
            r_lrclk  <= lrclk;
            r_edge_d <= w_edge;
        end
    end

    // Lock onto the first frame start and count bit positions within a frame.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_synced <= 1'b0;
            r_pos    <= '0;
        end else if (w_align) begin
            r_synced <= 1'b1;
            r_pos    <= PW'(1);
        end else if (r_synced) begin
            r_pos    <= f_pos_inc(r_pos);
        end
    end

    // ---- capture: serial shift and per-slot sample latch ----
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= w_word[AUDIO_DW-2:0];
        end
    end

    // Latch each channel word on its last kept bit; a bad frame start wipes partial data.
    always_ff @(posedge sclk) begin
        if (rst || w_sync_bad) begin
            r_buf <= '0;
        end else if (r_synced) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (r_pos == PW'(k * SLOT_W + AUDIO_DW - 1))
                    r_buf[k*AUDIO_DW +: AUDIO_DW] <= w_word;
            end
        end
    end

    // Full frame: stored channels plus the word finishing on this cycle.
    always_comb begin
        w_frame = r_buf;
        w_frame[(NUM_CH-1)*AUDIO_DW +: AUDIO_DW] = w_word;
    end

    // ---- output: one-deep frame slot with valid/ready and status pulses ----
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_sync_err <= w_sync_bad;
            if (w_complete) begin
                if (w_free) begin
                    r_data  <= w_frame;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && frm.frame_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign frm.frame_data  = r_data;
    assign frm.frame_valid = r_valid;
    assign frm.overrun     = r_overrun;
    assign frm.sync_err    = r_sync_err;
    assign frm.synced      = r_synced;
endmodule
